// File: rtl/demux7_ctrl.sv
// demux7_ctrl: flow-controlled dispatcher in front of the 7-way demux datapath.
// One tagged word per cycle is steered into one of seven single-entry holding
// slots, and each slot drains through its own valid/ready handshake.
// Select code 7 drops the word and counts the drop (saturating). When the
// macro DEMUX7_CTRL_BCAST_EN is defined, select code 7 instead broadcasts the
// word to all seven slots.
module demux7_ctrl #(
    parameter int WIDTH = 13,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_sel,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [WIDTH-1:0] out5,
    output logic [WIDTH-1:0] out6,
    output logic [6:0]       out_valid,
    input  logic [6:0]       out_ready,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             drop_err
);

`ifdef DEMUX7_CTRL_BCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    logic [WIDTH-1:0] slot_data [7];
    logic [6:0]       slot_free;
    logic [6:0]       load;
    logic             xfer_in;
    logic             sel_special;
    logic             drop;

    // A slot can take a word when it is empty or being drained this cycle.
    assign slot_free   = ~out_valid | out_ready;
    assign sel_special = (in_sel == 3'd7);
    assign xfer_in     = in_valid & in_ready;
    assign drop        = xfer_in & sel_special & ~BCAST;

    // Ready depends only on the selected destination(s), never on in_valid.
    always_comb begin
        in_ready = 1'b0;
        if (sel_special) begin
            in_ready = BCAST ? (&slot_free) : 1'b1;
        end else begin
            in_ready = slot_free[in_sel];
        end
    end

    // Per-slot load strobes; broadcast loads every slot in the same edge.
    always_comb begin
        load = '0;
        for (int i = 0; i < 7; i++) begin
            load[i] = xfer_in & ((in_sel == 3'(i)) | (sel_special & BCAST));
        end
    end

    // Slot registers: a fill wins over a concurrent drain so pass-through
    // keeps the slot valid with the new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            for (int i = 0; i < 7; i++) begin
                slot_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 7; i++) begin
                if (load[i]) begin
                    slot_data[i] <= in_data;
                    out_valid[i] <= 1'b1;
                end else if (out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Drop bookkeeping: pulse on every drop, counter sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_err <= 1'b0;
            drop_cnt <= '0;
        end else begin
            drop_err <= drop;
            if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    assign out0 = slot_data[0];
    assign out1 = slot_data[1];
    assign out2 = slot_data[2];
    assign out3 = slot_data[3];
    assign out4 = slot_data[4];
    assign out5 = slot_data[5];
    assign out6 = slot_data[6];

endmodule

// File: tb/tb_demux7_ctrl.sv
// Directed bench for demux7_ctrl. Exercises the broadcast path when built with
// DEMUX7_CTRL_BCAST_EN, otherwise the drop/count path.
module tb_demux7_ctrl;

    localparam int WIDTH = 13;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [2:0]       in_sel;
    logic [WIDTH-1:0] out0, out1, out2, out3, out4, out5, out6;
    logic [6:0]       out_valid;
    logic [6:0]       out_ready;
    logic [CNT_W-1:0] drop_cnt;
    logic             drop_err;

    int compared   = 0;
    int mismatched = 0;

    demux7_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out4      (out4),
        .out5      (out5),
        .out6      (out6),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop_cnt  (drop_cnt),
        .drop_err  (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] get_out(input int i);
        case (i)
            0: return out0;
            1: return out1;
            2: return out2;
            3: return out3;
            4: return out4;
            5: return out5;
            default: return out6;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_all();
        in_valid  = 1'b0;
        out_ready = 7'h7F;
        tick();
        chk("drain_all_valid", {25'd0, out_valid}, 32'h0);
    endtask

    initial begin
        int pulses;
        int ready_hi;

        // Reset held with a pending word for slot 2
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 3'd2;
        in_data   = 13'h1ABC;
        out_ready = 7'h00;
        #1;
        chk("rst_ready_comb", {31'd0, in_ready}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_out_valid", {25'd0, out_valid}, 32'h0);
            chk("rst_out2", {19'd0, out2}, 32'h0);
            chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'h0);
            chk("rst_drop_err", {31'd0, drop_err}, 32'h0);
        end
        rst_n = 1'b1;
        tick();
        chk("first_accept_out2", {19'd0, out2}, 32'h1ABC);
        chk("first_accept_valid", {25'd0, out_valid}, 32'h04);
        drain_all();

        // Back-pressure on slot 4
        out_ready = 7'h00;
        in_valid  = 1'b1;
        in_sel    = 3'd4;
        in_data   = 13'h0055;
        #1;
        chk("bp_ready_empty", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_out4_first", {19'd0, out4}, 32'h0055);
        chk("bp_valid_first", {25'd0, out_valid}, 32'h10);
        in_data = 13'h0AAA;
        #1;
        chk("bp_ready_full", {31'd0, in_ready}, 32'd0);
        tick();
        chk("bp_out4_held", {19'd0, out4}, 32'h0055);
        out_ready = 7'h10;
        #1;
        chk("bp_ready_drain", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_out4_second", {19'd0, out4}, 32'h0AAA);
        chk("bp_valid_second", {25'd0, out_valid}, 32'h10);
        drain_all();

        // Full-rate streaming across all seven slots
        out_ready = 7'h7F;
        in_valid  = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_sel  = 3'(i);
            in_data = 13'(i + 1);
            #1;
            chk("stream_ready", {31'd0, in_ready}, 32'd1);
            tick();
            chk("stream_out", {19'd0, get_out(i)}, 32'(i + 1));
            chk("stream_valid", {25'd0, out_valid}, 32'(1 << i));
        end
        drain_all();

        // Slot 3 stalled must not block the others
        out_ready = 7'b1110111;
        in_valid  = 1'b1;
        in_sel    = 3'd3;
        in_data   = 13'h0333;
        tick();
        for (int i = 0; i < 7; i++) begin
            if (i == 3) continue;
            in_sel  = 3'(i);
            in_data = 13'(12'h100 + i);
            #1;
            chk("indep_ready", {31'd0, in_ready}, 32'd1);
            tick();
            chk("indep_out", {19'd0, get_out(i)}, 32'(12'h100 + i));
            chk("indep_valid", {25'd0, out_valid}, 32'(8 | (1 << i)));
        end
        chk("indep_out3", {19'd0, out3}, 32'h0333);
        in_valid = 1'b0;
        in_sel   = 3'd3;
        #1;
        chk("indep_ready_sel3_idle", {31'd0, in_ready}, 32'd0);
        drain_all();

`ifdef DEMUX7_CTRL_BCAST_EN
        // Broadcast waits for every slot, including stalled slot 5
        out_ready = 7'h00;
        in_valid  = 1'b1;
        in_sel    = 3'd5;
        in_data   = 13'h0555;
        tick();
        in_sel  = 3'd7;
        in_data = 13'h0F0F;
        #1;
        chk("bc_ready_blocked", {31'd0, in_ready}, 32'd0);
        tick();
        chk("bc_out5_held", {19'd0, out5}, 32'h0555);
        chk("bc_valid_held", {25'd0, out_valid}, 32'h20);
        out_ready = 7'h20;
        #1;
        chk("bc_ready_open", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bc_valid_all", {25'd0, out_valid}, 32'h7F);
        for (int i = 0; i < 7; i++) begin
            chk("bc_out", {19'd0, get_out(i)}, 32'h0F0F);
        end
        chk("bc_drop_cnt", {24'd0, drop_cnt}, 32'h0);
        chk("bc_drop_err", {31'd0, drop_err}, 32'h0);
        in_valid = 1'b0;
`else
        // Drop path: 300 words to select 7 with slot 1 parked full
        out_ready = 7'h00;
        in_valid  = 1'b1;
        in_sel    = 3'd1;
        in_data   = 13'h0111;
        tick();
        in_sel   = 3'd7;
        pulses   = 0;
        ready_hi = 0;
        for (int n = 0; n < 300; n++) begin
            in_data = 13'(n);
            #1;
            if (in_ready === 1'b1) ready_hi++;
            tick();
            if (drop_err === 1'b1) pulses++;
            if (n == 9) chk("drop_cnt_10", {24'd0, drop_cnt}, 32'd10);
        end
        in_valid = 1'b0;
        tick();
        chk("drop_err_idle", {31'd0, drop_err}, 32'd0);
        chk("drop_ready_cycles", 32'(ready_hi), 32'd300);
        chk("drop_pulses", 32'(pulses), 32'd300);
        chk("drop_cnt_sat", {24'd0, drop_cnt}, 32'd255);
        chk("drop_valid_unchanged", {25'd0, out_valid}, 32'h02);
        chk("drop_out1_unchanged", {19'd0, out1}, 32'h0111);
`endif

        // Asynchronous reset mid-operation discards held words immediately
        out_ready = 7'h00;
        in_valid  = 1'b1;
        in_sel    = 3'd6;
        in_data   = 13'h0666;
        tick();
        chk("pre_rst_valid6", {31'd0, out_valid[6]}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {25'd0, out_valid}, 32'h0);
        chk("async_rst_out6", {19'd0, out6}, 32'h0);
        tick();
        chk("rst_no_xfer", {25'd0, out_valid}, 32'h0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        chk("post_rst_valid", {25'd0, out_valid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/demux7_ctrl.md
# demux7_ctrl

Registered, flow-controlled dispatcher in front of the 7-way 13-bit demultiplexer datapath. Accepts one tagged word per cycle on a valid/ready input stream and steers it into one of seven single-entry output holding slots. Each slot drains through its own valid/ready handshake. Words addressed to the unused select code 3'b111 are dropped and counted, or broadcast when the broadcast option is compiled in.

## Interface
- WIDTH, 13: data word width.
- CNT_W, 8: width of the saturating drop counter.

- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  controller can accept the word this cycle.
- in_data  input  WIDTH  word to dispatch.
- in_sel  input  3  destination, 0..6 select out0..out6, 7 is special.
- out0..out6  output  WIDTH each  registered slot data.
- out_valid  output  7  bit i set while slot i holds a word.
- out_ready  input  7  bit i set when consumer i takes the word this cycle.
- drop_cnt  output  CNT_W  number of dropped words, saturating.
- drop_err  output  1  one-cycle pulse on each drop.

## Operation
- Slot i is full while out_valid[i]=1. Transfer in: in_valid & in_ready. Transfer out: out_valid[i] & out_ready[i].
- in_sel=i (0..6): in_ready = !out_valid[i] | out_ready[i].
  - On transfer in, outi <= in_data and out_valid[i] <= 1.
  - Fill and drain of the same slot in one cycle: new word replaces the old one and out_valid stays 1. Pass-through is allowed at full throughput.
- Slot i drains without a fill: out_valid[i] <= 0. outi holds its last value, and outi is don't-care while out_valid[i]=0.
- Slots are independent. A drain on slot j never blocks or alters slot i.
- in_sel=7 without the broadcast option:
  - in_ready=1. The word is discarded and drop_err pulses the next cycle.
  - drop_cnt increments and saturates at 2^CNT_W-1. drop_err still pulses once saturated.
- in_valid=0: in_ready still reflects the current in_sel. No state changes except drains.
- Words for one destination stay in order. No ordering is guaranteed across destinations.

## Timing
- Reset (async assert, sync release): out0..out6=0, out_valid=0, drop_cnt=0, drop_err=0.
- Reset mid-operation: all held words are discarded and none are delivered. in_ready is valid combinationally during reset, but no transfer occurs while rst_n=0.
- Latency: a word accepted at edge N is visible on outi with out_valid[i]=1 after edge N, for consumption at edge N+1.
- in_ready is combinational from in_sel, out_valid and out_ready. There is no combinational path from in_valid to in_ready. out_valid, outi, drop_cnt and drop_err are registered.
- Throughput: one word per cycle when the target slot is empty or draining.

## Configuration
- DEMUX7_CTRL_BCAST_EN defined: in_sel=7 is a broadcast.
  - in_ready = AND over i of (!out_valid[i] | out_ready[i]).
  - On transfer in, all seven slots load in_data and set out_valid in the same edge.
  - No drop and no drop_err pulse. drop_cnt remains 0 forever.
- DEMUX7_CTRL_BCAST_EN undefined: in_sel=7 drops as described in Operation.
- All other behaviour is identical in both builds.

## Test plan
- Reset: hold rst_n=0 with in_valid=1, in_sel=2, in_data=13'h1ABC.
  - Required: all outputs 0 and out_valid=0 throughout.
  - After release, the first accept is seen on out2 one cycle later.
- Back-pressure: send 13'h0055 to sel 4 with out_ready=0.
  - Required: out4=13'h0055 and out_valid=7'b0010000 after 1 cycle.
  - A second word to sel 4 sees in_ready=0.
  - Asserting out_ready[4] accepts the second word the same cycle. out4 updates and out_valid[4] stays 1.
- Streaming and independence: stream sel 0,1,...,6 with in_data=i+1 and out_ready=all 1.
  - Required: one accept per cycle and each outi=i+1 one cycle later.
  - Stalling slot 3 does not block words to the other six slots.
- Drop, non-broadcast build: send 300 words with sel 7 and CNT_W=8.
  - Required: in_ready=1 throughout and 300 drop_err pulses.
  - drop_cnt=255 and no out_valid change.
- Broadcast build: slot 5 full and stalled, send sel 7 data 13'h0F0F.
  - Required: in_ready=0 until out_ready[5]=1.
  - Then all seven outputs hold 13'h0F0F with out_valid=7'h7F, and drop_cnt=0.
